// File: rtl/ddr_avmm_responder.sv
// Avalon-MM DDR stand-in backed by on-chip RAM with a fixed-latency read pipe.
// Define DDR_AVMM_RESPONDER_BACKPRESSURE_EN for LFSR-driven waitrequest stalls.
module ddr_avmm_responder #(
    parameter int DATA_WIDTH       = 512,
    parameter int ADDR_WIDTH       = 26,
    parameter int BYTEEN_WIDTH     = 64,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int READ_LATENCY     = 4
) (
    input  logic                        DDR_USERCLK,
    input  logic                        SoftReset_n,
    input  logic                        DDR_read,
    input  logic                        DDR_write,
    input  logic [ADDR_WIDTH-1:0]       DDR_address,
    input  logic [DATA_WIDTH-1:0]       DDR_writedata,
    input  logic [BYTEEN_WIDTH-1:0]     DDR_byteenable,
    input  logic [BURSTCOUNT_WIDTH-1:0] DDR_burstcount,
    output logic                        DDR_waitrequest,
    output logic                        DDR_readdatavalid,
    output logic [DATA_WIDTH-1:0]       DDR_readdata,
    output logic                        busy,
    output logic                        err_protocol
);
    localparam int BW  = BURSTCOUNT_WIDTH;
    localparam int MDL = MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t          state;
    logic            wait_q;
    logic            stall;
    logic [MDL-1:0]  base;
    logic [BW-1:0]   count;
    logic [BW-1:0]   beat;

    logic [DATA_WIDTH-1:0] mem [2**MDL];

    logic                  vld   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pdata [READ_LATENCY];
    logic                  any_vld;

    logic [BW-1:0]  bc_eff;
    logic [BW-1:0]  beat_nx;
    logic [BW-1:0]  beat_n2;
    logic [MDL-1:0] addr_lo;
    logic [MDL-1:0] off;
    logic [MDL-1:0] wr_idx;
    logic           issue;
    logic           last_rd;
    logic           can_cmd;
    logic           wr_fire;
    logic           cmd_wr;
    logic           rd_fire;
    logic           conflict;
    logic           unused_addr;

    assign unused_addr = ^DDR_address[ADDR_WIDTH-1:MDL];

    assign bc_eff  = (DDR_burstcount == '0) ? BW'(1) : DDR_burstcount;
    assign beat_nx = beat + BW'(1);
    assign beat_n2 = beat + BW'(2);
    assign addr_lo = DDR_address[MDL-1:0];
    assign off     = base + MDL'(beat);
    assign issue   = (state == RD_BURST);
    assign last_rd = issue && (beat_nx == count);
    // The last read-issue cycle also takes a new command so bursts chain.
    assign can_cmd = (state == IDLE) || last_rd;
    assign wr_fire = DDR_write && !DDR_waitrequest
                     && (can_cmd || state == WR_BURST);
    assign cmd_wr  = wr_fire && can_cmd;
    assign rd_fire = DDR_read && !DDR_write && !DDR_waitrequest && can_cmd;
    assign conflict = (can_cmd && DDR_read && DDR_write && !DDR_waitrequest)
                      || (state == WR_BURST && DDR_read);
    assign wr_idx  = (state == WR_BURST) ? off : addr_lo;

`ifdef DDR_AVMM_RESPONDER_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge DDR_USERCLK or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (state != RD_BURST) && (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign DDR_waitrequest = wait_q || stall;

    always_ff @(posedge DDR_USERCLK or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state        <= IDLE;
            wait_q       <= 1'b1;
            base         <= '0;
            count        <= '0;
            beat         <= '0;
            err_protocol <= 1'b0;
        end else begin
            wait_q <= 1'b0;
            if (conflict) begin
                err_protocol <= 1'b1;
            end
            unique case (state)
                IDLE: ;
                WR_BURST: begin
                    if (wr_fire) begin
                        beat <= beat_nx;
                        if (beat_nx == count) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    beat <= beat_nx;
                    if (last_rd) begin
                        state <= IDLE;
                    end else begin
                        wait_q <= (beat_n2 != count);
                    end
                end
                default: state <= IDLE;
            endcase
            if (cmd_wr) begin
                base  <= addr_lo;
                count <= bc_eff;
                beat  <= BW'(1);
                state <= (bc_eff == BW'(1)) ? IDLE : WR_BURST;
            end else if (rd_fire) begin
                base   <= addr_lo;
                count  <= bc_eff;
                beat   <= '0;
                state  <= RD_BURST;
                wait_q <= (bc_eff != BW'(1));
            end
        end
    end

    always_ff @(posedge DDR_USERCLK) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTEEN_WIDTH; i++) begin
                if (DDR_byteenable[i]) begin
                    mem[wr_idx][i*8 +: 8] <= DDR_writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge DDR_USERCLK or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld[i]   <= 1'b0;
                pdata[i] <= '0;
            end
        end else begin
            vld[0] <= issue;
            if (issue) begin
                pdata[0] <= mem[off];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    pdata[i] <= pdata[i-1];
                end
            end
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            any_vld = any_vld || vld[i];
        end
    end

    assign DDR_readdatavalid = vld[READ_LATENCY-1];
    assign DDR_readdata      = pdata[READ_LATENCY-1];
    assign busy              = (state != IDLE) || any_vld;

endmodule
